apb_pack_master: RTL and testbench

- Packet-driven APB3 master. Successor to the fixed 4-slave packet master, parametrised in slave count.
- Pops control and data packets from the downstream write FIFO and runs one APB transfer on the one-hot-selected slave.
- For reads, pushes the response word to the encrypt/response FIFO. Sits between the bridge FIFOs and the peripheral APB fabric.
- New relative to the previous generation: PSLVERR capture, a PREADY timeout, illegal-select rejection, an optional write-acknowledge response and an error counter.

---
 rtl/apb_pack_pkg.sv | 31 +++
 rtl/apb_pack_master_if.sv | 34 +++
 rtl/apb_slv_mux.sv | 43 ++++
 rtl/apb_pack_master.sv | 205 ++++++++++++++++++++
 tb/tb_apb_pack_master.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pack_pkg.sv
// Shared types and constants for the packet-driven APB3 master.
// Packet layout, FSM state encoding and error response words.
package apb_pack_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRdCtrl,
        StCapCtrl,
        StChk,
        StRdData,
        StCapData,
        StSetup,
        StAccess,
        StResp
    } state_t;

    localparam int unsigned FLAG_BIT = 0;
    localparam int unsigned WR_BIT   = 1;
    localparam int unsigned SEL_LSB  = 2;
    localparam int unsigned SEL_MSB  = 7;
    localparam int unsigned ADDR_LSB = 8;
    localparam int unsigned SEL_W    = SEL_MSB - SEL_LSB + 1;
    localparam int unsigned ADDR_W   = 32 - ADDR_LSB;

    localparam logic [31:0] ERR_ILLEGAL_SEL = 32'hDEAD_0001;
    localparam logic [31:0] ERR_SEQ         = 32'hDEAD_0002;
    localparam logic [31:0] ERR_TIMEOUT     = 32'hDEAD_0003;
    localparam logic [31:0] ERR_WR_SLVERR   = 32'hDEAD_0004;
    localparam logic [31:0] WR_OK           = 32'h0000_0000;

endpackage

// File: rtl/apb_pack_master_if.sv
// Bus bundle for apb_pack_master: request FIFO, response FIFO and APB fabric.
// master = the packet master's view, slave = the surrounding environment.
interface apb_pack_master_if #(
    parameter int unsigned NUM_SLV = 4
);
    logic                    fifo_empty;
    logic [31:0]             fifo_rdata;
    logic                    fifo_ren;

    logic                    resp_full;
    logic [31:0]             resp_data;
    logic                    resp_vld;
    logic                    resp_err;

    logic [NUM_SLV-1:0]      psel;
    logic                    penable;
    logic                    pwrite;
    logic [31:0]             paddr;
    logic [31:0]             pwdata;
    logic [NUM_SLV*32-1:0]   prdata;
    logic [NUM_SLV-1:0]      pready;
    logic [NUM_SLV-1:0]      pslverr;

    modport master (
        input  fifo_empty, fifo_rdata, resp_full, prdata, pready, pslverr,
        output fifo_ren, resp_data, resp_vld, resp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output fifo_empty, fifo_rdata, resp_full, prdata, pready, pslverr,
        input  fifo_ren, resp_data, resp_vld, resp_err, psel, penable, pwrite, paddr, pwdata
    );

endinterface

// File: rtl/apb_slv_mux.sv
// Decodes the one-hot select field into a slave index and legality flag,
// and steers that slave's prdata/pready/pslverr back to the master.
module apb_slv_mux
    import apb_pack_pkg::*;
#(
    parameter int unsigned NUM_SLV = 4
) (
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [NUM_SLV*32-1:0] prdata_i,
    input  logic [NUM_SLV-1:0]    pready_i,
    input  logic [NUM_SLV-1:0]    pslverr_i,
    output logic                  legal_o,
    output logic [31:0]           rdata_o,
    output logic                  ready_o,
    output logic                  slverr_o
);
    localparam int unsigned IDX_W = $clog2(SEL_W);

    logic [IDX_W-1:0] idx;

    always_comb begin
        idx      = '0;
        legal_o  = 1'b0;
        rdata_o  = '0;
        ready_o  = 1'b0;
        slverr_o = 1'b0;
        // Exact one-hot match only; zero or multi-hot leaves legal_o low.
        for (int i = 0; i < SEL_W; i++) begin
            if (sel_i == SEL_W'(1 << i)) begin
                idx     = IDX_W'(i);
                legal_o = (unsigned'(i) < NUM_SLV);
            end
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            if (legal_o && (idx == IDX_W'(i))) begin
                rdata_o  = prdata_i[32*i +: 32];
                ready_o  = pready_i[i];
                slverr_o = pslverr_i[i];
            end
        end
    end

endmodule

// File: rtl/apb_pack_master.sv
// Packet-driven APB3 master: pops control/data packets, runs one APB transfer on
// the selected slave and pushes read (and optionally write) responses.
module apb_pack_master
    import apb_pack_pkg::*;
#(
    parameter int unsigned NUM_SLV     = 4,
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter int unsigned WR_RESP_EN  = 0,
    parameter int unsigned ERR_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    apb_pack_master_if.master     bus,
    output logic                  busy,
    output logic [ERR_CNT_W-1:0]  err_cnt
);
    localparam int unsigned TMO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

    state_t               state_q, state_d;
    logic                 write_q, write_d;
    logic [SEL_W-1:0]     sel_q, sel_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [31:0]          resp_data_q, resp_data_d;
    logic                 resp_err_q, resp_err_d;
    logic                 resp_vld_q, resp_vld_d;
    logic [NUM_SLV-1:0]   psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 fifo_ren_q, fifo_ren_d;
    logic                 busy_q, busy_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic                 err_inc;

    logic                 sel_legal;
    logic [31:0]          mux_rdata;
    logic                 mux_ready;
    logic                 mux_slverr;

    apb_slv_mux #(
        .NUM_SLV (NUM_SLV)
    ) u_slv_mux (
        .sel_i     (sel_q),
        .prdata_i  (bus.prdata),
        .pready_i  (bus.pready),
        .pslverr_i (bus.pslverr),
        .legal_o   (sel_legal),
        .rdata_o   (mux_rdata),
        .ready_o   (mux_ready),
        .slverr_o  (mux_slverr)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        pwdata_d    = pwdata_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        resp_vld_d  = 1'b0;
        tmo_cnt_d   = tmo_cnt_q;
        err_inc     = 1'b0;

        case (state_q)
            StIdle: begin
                if (!bus.fifo_empty) state_d = StRdCtrl;
            end
            StRdCtrl: state_d = StCapCtrl;
            StCapCtrl: begin
                if (bus.fifo_rdata[FLAG_BIT]) begin
                    err_inc = 1'b1;
                    state_d = StIdle;
                end else begin
                    write_d  = bus.fifo_rdata[WR_BIT];
                    sel_d    = bus.fifo_rdata[SEL_MSB:SEL_LSB];
                    addr_d   = bus.fifo_rdata[31:ADDR_LSB];
                    pwdata_d = '0;
                    state_d  = StChk;
                end
            end
            StChk: begin
                // Writes always consume their data packet, even with an illegal select.
                if (write_q) begin
                    if (!bus.fifo_empty) state_d = StRdData;
                end else if (sel_legal) begin
                    state_d = StSetup;
                end else begin
                    resp_data_d = ERR_ILLEGAL_SEL;
                    resp_err_d  = 1'b1;
                    err_inc     = 1'b1;
                    state_d     = StResp;
                end
            end
            StRdData: state_d = StCapData;
            StCapData: begin
                if (!sel_legal) begin
                    resp_data_d = ERR_ILLEGAL_SEL;
                    resp_err_d  = 1'b1;
                    err_inc     = 1'b1;
                    state_d     = StResp;
                end else if (!bus.fifo_rdata[FLAG_BIT]) begin
                    resp_data_d = ERR_SEQ;
                    resp_err_d  = 1'b1;
                    err_inc     = 1'b1;
                    state_d     = StResp;
                end else begin
                    pwdata_d = {1'b0, bus.fifo_rdata[31:1]};
                    state_d  = StSetup;
                end
            end
            StSetup: begin
                tmo_cnt_d = '0;
                state_d   = StAccess;
            end
            StAccess: begin
                if (mux_ready) begin
                    err_inc = mux_slverr;
                    if (!write_q) begin
                        resp_data_d = mux_rdata;
                        resp_err_d  = mux_slverr;
                        state_d     = StResp;
                    end else if (WR_RESP_EN != 0) begin
                        resp_data_d = mux_slverr ? ERR_WR_SLVERR : WR_OK;
                        resp_err_d  = mux_slverr;
                        state_d     = StResp;
                    end else begin
                        state_d = StIdle;
                    end
                end else if ((TIMEOUT_CYC != 0) && (tmo_cnt_q == TMO_W'(TMO_LAST))) begin
                    resp_data_d = ERR_TIMEOUT;
                    resp_err_d  = 1'b1;
                    err_inc     = 1'b1;
                    state_d     = StResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            StResp: begin
                if (!bus.resp_full) begin
                    resp_vld_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != {ERR_CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;

        // Outputs are registered images of the next state.
        psel_d     = ((state_d == StSetup) || (state_d == StAccess)) ? sel_q[NUM_SLV-1:0] : '0;
        penable_d  = (state_d == StAccess);
        fifo_ren_d = (state_d == StRdCtrl) || (state_d == StRdData);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            pwdata_q    <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            resp_vld_q  <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            fifo_ren_q  <= 1'b0;
            busy_q      <= 1'b0;
            err_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            pwdata_q    <= pwdata_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            resp_vld_q  <= resp_vld_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            fifo_ren_q  <= fifo_ren_d;
            busy_q      <= busy_d;
            err_cnt_q   <= err_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign bus.fifo_ren  = fifo_ren_q;
    assign bus.resp_data = resp_data_q;
    assign bus.resp_vld  = resp_vld_q;
    assign bus.resp_err  = resp_err_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = write_q;
    assign bus.paddr     = {8'h00, addr_q};
    assign bus.pwdata    = pwdata_q;
    assign busy          = busy_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_apb_pack_master.sv
// Directed bench for apb_pack_master: request FIFO and APB slave models,
// hand-computed expectations checked with immediate assertions.
module tb_apb_pack_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [7:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] req_mem [64];
    int          req_wr  = 0;
    int          req_rd  = 0;
    int          acc_cnt = 0;
    int          wait_n  = 0;

    int          n_psel, n_pen, n_vld, n_busy;
    logic [3:0]  last_psel;
    logic [31:0] vld_data, cap_paddr, cap_pwdata;
    logic        vld_err, cap_pwrite;
    bit          found;

    apb_pack_master_if #(.NUM_SLV(4)) ifc ();

    apb_pack_master #(
        .NUM_SLV     (4),
        .TIMEOUT_CYC (16),
        .WR_RESP_EN  (1),
        .ERR_CNT_W   (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifc),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    assign ifc.fifo_empty = (req_wr == req_rd);

    always @(posedge clk) begin
        if (ifc.fifo_ren) begin
            ifc.fifo_rdata <= req_mem[req_rd % 64];
            req_rd         <= req_rd + 1;
        end
        acc_cnt <= ifc.penable ? acc_cnt + 1 : 0;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ifc.pready[i] = ifc.psel[i] && ifc.penable && (acc_cnt >= wait_n);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl(input logic wr, input logic [5:0] sel,
                                         input logic [23:0] addr);
        return {addr, sel, wr, 1'b0};
    endfunction

    task automatic push(input logic [31:0] w);
        req_mem[req_wr % 64] = w;
        req_wr++;
    endtask

    // Steps until busy has risen and fallen again, logging bus activity per cycle.
    task automatic run_txn(input string tag, input int budget);
        bit started = 1'b0;
        bit done    = 1'b0;
        n_psel = 0; n_pen = 0; n_vld = 0; n_busy = 0;
        last_psel = '0; vld_data = '0; vld_err = 1'b0;
        cap_paddr = '0; cap_pwdata = '0; cap_pwrite = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (ifc.psel != 4'b0) begin
                n_psel++;
                last_psel  = ifc.psel;
                cap_paddr  = ifc.paddr;
                cap_pwdata = ifc.pwdata;
                cap_pwrite = ifc.pwrite;
            end
            if (ifc.penable) n_pen++;
            if (ifc.resp_vld) begin
                n_vld++;
                vld_data = ifc.resp_data;
                vld_err  = ifc.resp_err;
            end
            if (busy) begin
                n_busy++;
                started = 1'b1;
            end else if (started) begin
                done = 1'b1;
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        rst_n           = 1'b0;
        ifc.resp_full   = 1'b0;
        ifc.pslverr     = 4'b0;
        ifc.prdata      = {32'h3333_3333, 32'h2222_2222, 32'h1234_5678, 32'hAAAA_0000};
        #1;
        chk("rst_psel",     32'(ifc.psel), 32'd0);
        chk("rst_penable",  32'(ifc.penable), 32'd0);
        chk("rst_fifo_ren", 32'(ifc.fifo_ren), 32'd0);
        chk("rst_resp_vld", 32'(ifc.resp_vld), 32'd0);
        chk("rst_resp_data", ifc.resp_data, 32'd0);
        chk("rst_paddr",    ifc.paddr, 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_err_cnt",  32'(err_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Read, slave 1, two wait states.
        wait_n = 2;
        push(ctrl(1'b0, 6'b000010, 24'h00_0010));
        run_txn("rd_ws2", 60);
        chk("rd_ws2_psel_cyc", 32'(n_psel), 32'd4);
        chk("rd_ws2_psel",     32'(last_psel), 32'h2);
        chk("rd_ws2_pen_cyc",  32'(n_pen), 32'd3);
        chk("rd_ws2_paddr",    cap_paddr, 32'h0000_0010);
        chk("rd_ws2_vld_cnt",  32'(n_vld), 32'd1);
        chk("rd_ws2_data",     vld_data, 32'h1234_5678);
        chk("rd_ws2_err",      32'(vld_err), 32'd0);
        chk("rd_ws2_busy_cyc", 32'(n_busy), 32'd8);

        // Zero-wait read, slave 2: minimum IDLE-to-IDLE of 7 cycles (6 busy).
        wait_n = 0;
        push(ctrl(1'b0, 6'b000100, 24'hAB_CDEF));
        run_txn("rd_ws0", 60);
        chk("rd_ws0_busy_cyc", 32'(n_busy), 32'd6);
        chk("rd_ws0_paddr",    cap_paddr, 32'h00AB_CDEF);
        chk("rd_ws0_data",     vld_data, 32'h2222_2222);

        // Write, slave 0, payload shifted down by one.
        push(ctrl(1'b1, 6'b000001, 24'h00_0004));
        push(32'h0000_0AAB);
        run_txn("wr", 60);
        chk("wr_pwdata", cap_pwdata, 32'h0000_0555);
        chk("wr_pwrite", 32'(cap_pwrite), 32'd1);
        chk("wr_psel",   32'(last_psel), 32'h1);
        chk("wr_vld",    32'(n_vld), 32'd1);
        chk("wr_data",   vld_data, 32'h0);
        chk("wr_err",    32'(vld_err), 32'd0);
        chk("wr_errcnt", 32'(err_cnt), 32'd0);

        // Read, slave 3 with PSLVERR.
        ifc.pslverr = 4'b1000;
        push(ctrl(1'b0, 6'b001000, 24'h00_0100));
        run_txn("rd_slverr", 60);
        chk("rd_slverr_data",   vld_data, 32'h3333_3333);
        chk("rd_slverr_err",    32'(vld_err), 32'd1);
        chk("rd_slverr_errcnt", 32'(err_cnt), 32'd1);
        ifc.pslverr = 4'b0;

        // Multi-hot select: no APB cycle.
        push(ctrl(1'b0, 6'b000011, 24'h00_0020));
        run_txn("illsel", 60);
        chk("illsel_psel_cyc", 32'(n_psel), 32'd0);
        chk("illsel_data",     vld_data, 32'hDEAD_0001);
        chk("illsel_err",      32'(vld_err), 32'd1);
        chk("illsel_errcnt",   32'(err_cnt), 32'd2);

        // PREADY never rises: abort after 16 ACCESS cycles.
        wait_n = 1000;
        push(ctrl(1'b0, 6'b000001, 24'h00_0040));
        run_txn("tmo", 80);
        chk("tmo_pen_cyc",  32'(n_pen), 32'd16);
        chk("tmo_psel_cyc", 32'(n_psel), 32'd17);
        chk("tmo_data",     vld_data, 32'hDEAD_0003);
        chk("tmo_err",      32'(vld_err), 32'd1);
        chk("tmo_errcnt",   32'(err_cnt), 32'd3);
        wait_n = 0;

        // Response FIFO full: push held off, then exactly one strobe.
        ifc.resp_full = 1'b1;
        push(ctrl(1'b0, 6'b000010, 24'h00_0030));
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (ifc.penable) found = 1'b1;
        end
        chk("full_access_seen", 32'(found), 32'd1);
        n_vld = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifc.resp_vld) n_vld++;
        end
        chk("full_no_push",   32'(n_vld), 32'd0);
        chk("full_busy_held", 32'(busy), 32'd1);
        ifc.resp_full = 1'b0;
        @(negedge clk);
        chk("full_vld_on",  32'(ifc.resp_vld), 32'd1);
        chk("full_data",    ifc.resp_data, 32'h1234_5678);
        @(negedge clk);
        chk("full_vld_off", 32'(ifc.resp_vld), 32'd0);
        chk("full_idle",    32'(busy), 32'd0);

        // Data packet where a control packet was expected: dropped silently.
        push(32'h0000_0001);
        run_txn("drop", 40);
        chk("drop_vld",    32'(n_vld), 32'd0);
        chk("drop_psel",   32'(n_psel), 32'd0);
        chk("drop_errcnt", 32'(err_cnt), 32'd4);

        // Write followed by a control packet instead of data.
        push(ctrl(1'b1, 6'b000001, 24'h00_0008));
        push(32'h0000_0002);
        run_txn("seq", 40);
        chk("seq_psel",   32'(n_psel), 32'd0);
        chk("seq_data",   vld_data, 32'hDEAD_0002);
        chk("seq_errcnt", 32'(err_cnt), 32'd5);

        // Write to select index 4 (beyond NUM_SLV): data still consumed.
        push(ctrl(1'b1, 6'b010000, 24'h00_000C));
        push(32'h0000_0003);
        run_txn("illwr", 40);
        chk("illwr_psel",    32'(n_psel), 32'd0);
        chk("illwr_data",    vld_data, 32'hDEAD_0001);
        chk("illwr_drained", 32'(req_rd), 32'(req_wr));
        chk("illwr_errcnt",  32'(err_cnt), 32'd6);

        // Write with PSLVERR on slave 2.
        ifc.pslverr = 4'b0100;
        push(ctrl(1'b1, 6'b000100, 24'h00_0020));
        push(32'h0000_0011);
        run_txn("wrerr", 60);
        chk("wrerr_pwdata", cap_pwdata, 32'h0000_0008);
        chk("wrerr_data",   vld_data, 32'hDEAD_0004);
        chk("wrerr_err",    32'(vld_err), 32'd1);
        chk("wrerr_errcnt", 32'(err_cnt), 32'd7);
        ifc.pslverr = 4'b0;

        // Reset pulsed mid-ACCESS.
        wait_n = 1000;
        push(ctrl(1'b0, 6'b000010, 24'h00_0050));
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (ifc.penable) found = 1'b1;
        end
        chk("mrst_access_seen", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_psel",    32'(ifc.psel), 32'd0);
        chk("mrst_penable", 32'(ifc.penable), 32'd0);
        chk("mrst_busy",    32'(busy), 32'd0);
        chk("mrst_errcnt",  32'(err_cnt), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        wait_n = 0;
        n_vld  = 0;
        n_busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.resp_vld) n_vld++;
            if (busy) n_busy++;
        end
        chk("mrst_no_push", 32'(n_vld), 32'd0);
        chk("mrst_idle",    32'(n_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
